// File: rtl/tspi_master_ctrl.sv
// tspi_master_ctrl: single-request TSPI master sequencer.
// Runs a full-duplex, mode-0 (CPOL=0, CPHA=0), MSB-first exchange of 1..DataWidth bits
// with a programmable SCK half-period, and returns the received word over a
// valid/ready response channel. All outputs come straight from registers.
module tspi_master_ctrl #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned ClkDivWidth = 8,
    parameter int unsigned LenWidth    = $clog2(DataWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [ClkDivWidth-1:0] cfg_clk_div_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [DataWidth-1:0]   req_data_i,
    input  logic [LenWidth-1:0]    req_len_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_data_o,
    output logic                   busy_o,
    output logic                   tspi_clk_o,
    output logic                   tspi_mosi_o,
    input  logic                   tspi_miso_i,
    output logic                   tspi_cs_no
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RESP     = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [ClkDivWidth-1:0] div_q, div_d;      // latched half-period minus one
    logic [ClkDivWidth-1:0] cnt_q, cnt_d;      // cycles spent in the current half-period
    logic [LenWidth-1:0]    bit_q, bit_d;      // index of the bit currently on MOSI
    logic [DataWidth-1:0]   tx_q, tx_d;        // latched transmit word
    logic [DataWidth-1:0]   rx_q, rx_d;        // receive shift register, LSB-first fill
    logic [DataWidth-1:0]   rsp_data_q, rsp_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   req_ready_q, req_ready_d;
    logic                   busy_q, busy_d;
    logic                   sck_q, sck_d;
    logic                   mosi_q, mosi_d;
    logic                   cs_n_q, cs_n_d;

    logic [LenWidth-1:0]    req_len_clamped;
    logic                   half_done;

    // Lengths beyond the word width can only be encoded when DataWidth is not a power of two.
    if ((1 << LenWidth) > DataWidth) begin : g_len_clamp
        assign req_len_clamped = (req_len_i > LenWidth'(DataWidth - 1)) ?
                                 LenWidth'(DataWidth - 1) : req_len_i;
    end else begin : g_len_pass
        assign req_len_clamped = req_len_i;
    end

    assign half_done = (cnt_q == div_q);

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    state_d     = ST_SETUP;
                    div_d       = cfg_clk_div_i;
                    cnt_d       = '0;
                    bit_d       = req_len_clamped;
                    tx_d        = req_data_i;
                    rx_d        = '0;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    cs_n_d      = 1'b0;
                    mosi_d      = req_data_i[req_len_clamped];
                end
            end
            ST_SETUP: begin
                if (half_done) begin
                    // First rising SCK edge: MISO is captured on the same clk_i edge.
                    state_d = ST_SHIFT_HI;
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[DataWidth-2:0], tspi_miso_i};
                end else begin
                    cnt_d = cnt_q + ClkDivWidth'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (half_done) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (bit_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Falling edge: present the next lower bit for the following rise.
                        state_d = ST_SHIFT_LO;
                        bit_d   = bit_q - LenWidth'(1);
                        mosi_d  = tx_q[bit_q - LenWidth'(1)];
                    end
                end else begin
                    cnt_d = cnt_q + ClkDivWidth'(1);
                end
            end
            ST_SHIFT_LO: begin
                if (half_done) begin
                    state_d = ST_SHIFT_HI;
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[DataWidth-2:0], tspi_miso_i};
                end else begin
                    cnt_d = cnt_q + ClkDivWidth'(1);
                end
            end
            ST_HOLD: begin
                if (half_done) begin
                    state_d     = ST_RESP;
                    cnt_d       = '0;
                    cs_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_data_d  = rx_q;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ClkDivWidth'(1);
                end
            end
            ST_RESP: begin
                // A pending request is only taken once back in IDLE, one cycle later.
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                sck_d       = 1'b0;
                mosi_d      = 1'b0;
                cs_n_d      = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops any partial transfer immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign tspi_clk_o  = sck_q;
    assign tspi_mosi_o = mosi_q;
    assign tspi_cs_no  = cs_n_q;

endmodule

// File: doc/tspi_master_ctrl.md
Name: tspi_master_ctrl

Overview:
Sequencer for the chip-level TSPI pins (tspi_clk_o, tspi_mosi_o, tspi_miso_i, tspi_cs_no). It accepts one transfer request at a time over a valid/ready handshake and runs a full-duplex, mode-0, MSB-first serial exchange of 1..DataWidth bits. SCK is generated from the system clock by a programmable divider. The received word is returned over a valid/ready response channel. It sits inside croc_soc between the peripheral register interface and the TSPI pads.

Parameters:
DataWidth, 32, maximum bits per transfer; also the width of the request and response data.
ClkDivWidth, 8, width of the SCK half-period divider configuration.
LenWidth, $clog2(DataWidth), width of the transfer-length field.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
cfg_clk_div_i  input  ClkDivWidth  SCK half-period minus one, in clk_i cycles; sampled at request accept
req_valid_i  input  1  transfer request valid
req_ready_o  output  1  controller can accept a request
req_data_i  input  DataWidth  transmit data; bits [req_len_i:0] are sent
req_len_i  input  LenWidth  number of bits minus one
rsp_valid_o  output  1  received data valid
rsp_ready_i  input  1  consumer accepts the response
rsp_data_o  output  DataWidth  received bits, right-aligned, upper bits zero
busy_o  output  1  high whenever state is not IDLE
tspi_clk_o  output  1  serial clock (CPOL=0)
tspi_mosi_o  output  1  serial data out
tspi_miso_i  input  1  serial data in
tspi_cs_no  output  1  chip select, active low

Behaviour:
- Clock and reset: a single clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, busy_o=0, tspi_clk_o=0, tspi_mosi_o=0, tspi_cs_no=1.
- Definitions:
  - H = cfg_clk_div_i+1, latched at accept (range 1..2^ClkDivWidth).
  - N = req_len_i+1, latched at accept.
  - Later changes to cfg_clk_div_i or req_* have no effect on an accepted transfer.
- Outputs are driven from registers; there are no combinational paths from pins to outputs.
- State machine:
  - IDLE: req_ready_o=1. A request is accepted when req_valid_i&&req_ready_o, giving the next state SETUP. At the transition: tspi_cs_no=0, tspi_mosi_o=req_data_i[req_len_i], half-period counter cleared, bit counter=N-1.
  - SETUP: SCK=0 for H cycles. Then go to SHIFT_HI and drive SCK=1.
  - SHIFT_HI: MISO is sampled into the shift register LSB on the same clk_i edge that drives SCK 1→0→1 high, i.e., on entry to SHIFT_HI. SCK=1 for H cycles.
    - At the end, if bit counter==0, go to HOLD (SCK=0).
    - Otherwise go to SHIFT_LO (SCK=0), decrement the bit counter and drive MOSI with the next lower bit.
  - SHIFT_LO: SCK=0 for H cycles, then go to SHIFT_HI.
  - HOLD: SCK=0 and CS still low for H cycles. Then tspi_cs_no=1, tspi_mosi_o=0, rsp_data_o=the received bits (zero-extended), rsp_valid_o=1, and go to RESP.
  - RESP: rsp_valid_o is held and rsp_data_o is stable until rsp_ready_i. On the handshake: rsp_valid_o=0, go to IDLE. req_ready_o=0 in this state.
- CS timing:
  - CS low duration = H*(2N+1) cycles.
  - SCK produces exactly N rising edges, with high and low times of exactly H cycles.
- Between transfers: tspi_cs_no stays high for at least 2 cycles (HOLD→RESP, then RESP→IDLE). An IDLE accept in the cycle after the rsp handshake is legal.
- Simultaneous rsp handshake and req_valid_i: the request is not accepted until the cycle the FSM is in IDLE.
- N=1 (req_len_i=0): SETUP, one SHIFT_HI, HOLD. CS low for 3H cycles.
- req_len_i>DataWidth-1 (only reachable when DataWidth is not a power of two): clamp to DataWidth-1.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Any partial transfer is dropped with no response.

Test Plan:
1. div=0, len=7, data=0xA5, MISO looped back to MOSI → rsp_data_o=0x000000A5. CS low exactly 17 cycles. 8 SCK pulses, each 1 cycle high.
2. div=3, len=3, data=0xC, MISO tied 1 → rsp_data_o=0xF. SCK high/low 4 cycles each. CS low 36 cycles. MOSI stable across every rising edge.
3. div=0, len=31, data=0xDEADBEEF, MISO driven by a slave model returning 0x12345678 → rsp_data_o=0x12345678. MOSI bit order matches MSB first.
4. rsp_ready_i held low 10 cycles after rsp_valid_o rises → rsp_valid_o and rsp_data_o stay stable. req_ready_o=0 throughout. A new req_valid_i is not accepted until the cycle after the handshake.
5. rst_ni pulsed low during SHIFT_HI of bit 4 → cs_no=1, clk=0, mosi=0, busy_o=0 asynchronously. No rsp_valid_o afterwards. The next request completes normally.
6. Back-to-back: req_valid_i held, cfg_clk_div_i changed from 1 to 0 mid-transfer → first transfer keeps a 2-cycle half-period. CS is high ≥2 cycles between transfers. The second transfer uses a 1-cycle half-period.
